random_stream_monitor: RTL and testbench
========================================

# random_stream_monitor

Consumer-side quality monitor for the CA-based random word generators. It accepts a stream of random words over a valid/ready handshake and accumulates per-window statistics: ones count, bit transitions and longest run of identical bits. At the end of each window it reports the totals and a pass/fail verdict. It sits between a generator and the genetic operators, gating or flagging degenerate CA rule/seed combinations.

## Interface
- Width, 32, bits per random word
- WindowWords, 64, accepted words per measurement window (≥1)
- OnesLow, 960, minimum ones count for pass (inclusive)
- OnesHigh, 1088, maximum ones count for pass (inclusive)
- MaxRun, 20, maximum allowed longest run for pass (inclusive)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: clear accumulators, begin new window
- in_valid  in  1  random word valid
- in_ready  out  1  monitor accepts a word this cycle
- in_data  in  Width  random word; bit 0 is the first bit in stream order
- done  out  1  one-cycle pulse: window complete, results valid
- ones_count  out  CW  ones in window, CW = clog2(Width*WindowWords+1)
- transitions  out  CW  adjacent-bit changes in window (stream order, across word boundaries)
- max_run  out  CW  longest run of identical bits in window
- pass  out  1  ones_count in [OnesLow, OnesHigh] and max_run ≤ MaxRun

## Operation
- FSM states: IDLE, ACCUM, REPORT.
- IDLE: in_ready=0. start → ACCUM. Clear word counter, accumulators, run counter and first-word flag.
- ACCUM: in_ready=1. Each accept (in_valid & in_ready):
  - ones_acc += popcount(in_data).
  - trans_acc += internal transitions. Add 1 more if this is not the first word and prev_last_bit ≠ in_data[0].
  - Run tracking is continuous across words. cur_run extends with the leading run of the word if in_data[0] == prev_last_bit, otherwise it restarts. max_acc takes the max of all runs closed or extended this word. Store prev_last_bit = in_data[Width-1].
  - word counter increments. On accept of word WindowWords-1 → REPORT.
- REPORT (one cycle): done=1. Output registers load from the accumulators. pass is computed from the loaded values. → IDLE.
- Outputs ones_count/transitions/max_run/pass hold their values until the next REPORT or until rst.
- start in any state (including ACCUM, REPORT): clears the accumulators, enters ACCUM next cycle, and takes priority over an accept in the same cycle (that word is discarded). Previously reported outputs are kept.
- Arithmetic: all accumulators are CW bits wide. Totals cannot exceed Width*WindowWords, so no saturation is needed. The ones compare is unsigned.
- Reset: state=IDLE; in_ready, done, pass, ones_count, transitions, max_run all 0; accumulators cleared. Reset mid-window aborts with no done.

## Timing
- in_ready is a registered function of state. It is high on the cycle after start and stays high until the final accept.
- Accepts may be non-consecutive. in_valid gaps simply stall.
- done asserts exactly 1 cycle after the final accept. The result outputs are valid and stable on that same cycle.
- Minimum window duration: 1 (start) + WindowWords + 1 (REPORT) cycles. in_ready is low during REPORT.
- Back-to-back windows require a new start. The earliest is a start on the done cycle, which gives ACCUM on the next cycle.

## Structure
- Package random_monitor_pkg: state enum (IDLE/ACCUM/REPORT), count_width(Width, WindowWords) function, default threshold constants.
- Sub-module random_word_stats is purely combinational per word. It outputs popcount, internal transitions, leading run length, trailing run length and longest internal run. The top level holds the FSM, cross-word carry and accumulators.

## Test plan
Test config: Width=8, WindowWords=4, OnesLow=12, OnesHigh=20, MaxRun=6.
- 4× 0xFF back-to-back → done 1 cycle after 4th accept; ones=32, transitions=0, max_run=32, pass=0.
- 4× 0x55 → ones=16, transitions=31 (boundary 0→1 counted), max_run=1, pass=1.
- 0xF0, 0x0F, 0xF0, 0x0F → ones=16, transitions=4, max_run=8 (run spans word boundary), pass=0.
- 0x55 ×4 with in_valid toggling every other cycle → in_ready 0 in IDLE and REPORT; same results as the 0x55 case; done exactly one cycle.
- Two 0xFF accepted, then start (with a valid word in the same cycle), then 4× 0x55 → results equal the 0x55 case; the colliding word is ignored.
- rst asserted after 2 accepts → next cycle all outputs 0, in_ready=0, no done until a new start.

Source files
------------

// File: rtl/random_monitor_pkg.sv
// Shared types and defaults for the random stream quality monitor.
package random_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_WINDOW_WORDS = 64;
    localparam int DEF_ONES_LOW     = 960;
    localparam int DEF_ONES_HIGH    = 1088;
    localparam int DEF_MAX_RUN      = 20;

    // Wide enough to hold every total a window can produce.
    function automatic int count_width(input int width, input int window_words);
        return $clog2(width * window_words + 1);
    endfunction

endpackage

// File: rtl/random_word_stats.sv
// Per-word bit statistics: popcount, internal transitions and run lengths (bit 0 first).
module random_word_stats #(
    parameter int Width = 32,
    localparam int SW = $clog2(Width + 1)
) (
    input  logic [Width-1:0] data_i,
    output logic [SW-1:0]    popcount_o,
    output logic [SW-1:0]    trans_o,
    output logic [SW-1:0]    lead_run_o,
    output logic [SW-1:0]    trail_run_o,
    output logic [SW-1:0]    max_run_o
);

    logic [SW-1:0] pop;
    logic [SW-1:0] trans;
    logic [SW-1:0] run;
    logic [SW-1:0] best;
    logic [SW-1:0] lead;
    logic          lead_done;

    // The run still open after the last bit is the trailing run.
    always_comb begin
        pop       = SW'(data_i[0]);
        trans     = '0;
        run       = SW'(1);
        best      = SW'(1);
        lead      = SW'(Width);
        lead_done = 1'b0;
        for (int i = 1; i < Width; i++) begin
            pop = pop + SW'(data_i[i]);
            if (data_i[i] != data_i[i-1]) begin
                trans = trans + SW'(1);
                if (!lead_done) begin
                    lead      = SW'(i);
                    lead_done = 1'b1;
                end
                run = SW'(1);
            end else begin
                run = run + SW'(1);
            end
            if (run > best) begin
                best = run;
            end
        end
    end

    assign popcount_o  = pop;
    assign trans_o     = trans;
    assign lead_run_o  = lead;
    assign trail_run_o = run;
    assign max_run_o   = best;

endmodule

// File: rtl/random_stream_monitor.sv
// Window-based quality monitor for a random word stream: ones, transitions, longest run, verdict.
module random_stream_monitor
    import random_monitor_pkg::*;
#(
    parameter int Width       = DEF_WIDTH,
    parameter int WindowWords = DEF_WINDOW_WORDS,
    parameter int OnesLow     = DEF_ONES_LOW,
    parameter int OnesHigh    = DEF_ONES_HIGH,
    parameter int MaxRun      = DEF_MAX_RUN,
    localparam int CW = count_width(Width, WindowWords)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             done,
    output logic [CW-1:0]    ones_count,
    output logic [CW-1:0]    transitions,
    output logic [CW-1:0]    max_run,
    output logic             pass,
    output logic [1:0]       state_dbg
);

    // Handshake: a word is taken on a rising edge where in_valid && in_ready;
    // in_ready is high only in ACCUM, and in_data must be stable while in_valid waits.

    localparam int SW  = $clog2(Width + 1);
    localparam int WCW = $clog2(WindowWords + 1);

    state_e         state_q;
    logic           in_ready_q;
    logic           done_q;
    logic           pass_q;
    logic [CW-1:0]  ones_out_q;
    logic [CW-1:0]  trans_out_q;
    logic [CW-1:0]  max_out_q;
    logic [CW-1:0]  ones_acc_q, ones_acc_d;
    logic [CW-1:0]  trans_acc_q, trans_acc_d;
    logic [CW-1:0]  max_acc_q, max_acc_d;
    logic [CW-1:0]  cur_run_q, cur_run_d;
    logic [WCW-1:0] word_cnt_q;
    logic           first_q;
    logic           prev_last_q;

    logic [SW-1:0]  w_pop, w_trans, w_lead, w_trail, w_max;
    logic           accept;
    logic           last_word;
    logic           boundary;
    logic [CW-1:0]  lead_len;
    logic           pass_d;

    random_word_stats #(.Width(Width)) u_stats (
        .data_i      (in_data),
        .popcount_o  (w_pop),
        .trans_o     (w_trans),
        .lead_run_o  (w_lead),
        .trail_run_o (w_trail),
        .max_run_o   (w_max)
    );

    assign accept    = in_valid && in_ready_q;
    assign last_word = (word_cnt_q == WCW'(WindowWords - 1));

    // Cross-word carry: the open run from the previous word joins this word's leading run.
    always_comb begin
        boundary    = !first_q && (prev_last_q != in_data[0]);
        lead_len    = (!first_q && !boundary) ? cur_run_q + CW'(w_lead) : CW'(w_lead);
        ones_acc_d  = ones_acc_q + CW'(w_pop);
        trans_acc_d = trans_acc_q + CW'(w_trans) + CW'(boundary);
        cur_run_d   = (w_lead == SW'(Width)) ? lead_len : CW'(w_trail);
        max_acc_d   = max_acc_q;
        if (lead_len > max_acc_d) begin
            max_acc_d = lead_len;
        end
        if (CW'(w_max) > max_acc_d) begin
            max_acc_d = CW'(w_max);
        end
        pass_d = (ones_acc_d >= CW'(OnesLow)) && (ones_acc_d <= CW'(OnesHigh)) &&
                 (max_acc_d <= CW'(MaxRun));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ones_out_q  <= '0;
            trans_out_q <= '0;
            max_out_q   <= '0;
            ones_acc_q  <= '0;
            trans_acc_q <= '0;
            max_acc_q   <= '0;
            cur_run_q   <= '0;
            word_cnt_q  <= '0;
            first_q     <= 1'b1;
            prev_last_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state_q     <= ACCUM;
                in_ready_q  <= 1'b1;
                ones_acc_q  <= '0;
                trans_acc_q <= '0;
                max_acc_q   <= '0;
                cur_run_q   <= '0;
                word_cnt_q  <= '0;
                first_q     <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        in_ready_q  <= 1'b0;
                        ones_acc_q  <= '0;
                        trans_acc_q <= '0;
                        max_acc_q   <= '0;
                        cur_run_q   <= '0;
                        word_cnt_q  <= '0;
                        first_q     <= 1'b1;
                    end
                    ACCUM: begin
                        if (accept) begin
                            ones_acc_q  <= ones_acc_d;
                            trans_acc_q <= trans_acc_d;
                            max_acc_q   <= max_acc_d;
                            cur_run_q   <= cur_run_d;
                            prev_last_q <= in_data[Width-1];
                            first_q     <= 1'b0;
                            word_cnt_q  <= word_cnt_q + WCW'(1);
                            // Results land on the same edge that enters REPORT.
                            if (last_word) begin
                                state_q     <= REPORT;
                                in_ready_q  <= 1'b0;
                                done_q      <= 1'b1;
                                ones_out_q  <= ones_acc_d;
                                trans_out_q <= trans_acc_d;
                                max_out_q   <= max_acc_d;
                                pass_q      <= pass_d;
                            end
                        end
                    end
                    REPORT: begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b0;
                    end
                    default: begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign ones_count  = ones_out_q;
    assign transitions = trans_out_q;
    assign max_run     = max_out_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_random_stream_monitor.sv
// Directed bench for random_stream_monitor with an 8-bit word, 4-word window.
module tb_random_stream_monitor;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       done;
    logic [5:0] ones_count;
    logic [5:0] transitions;
    logic [5:0] max_run;
    logic       pass;
    logic [1:0] state_dbg;

    int n_checks;
    int n_pass;
    int done_seen;

    random_stream_monitor #(
        .Width(8), .WindowWords(4), .OnesLow(12), .OnesHigh(20), .MaxRun(6)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .done(done), .ones_count(ones_count), .transitions(transitions),
        .max_run(max_run), .pass(pass), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] w[4], input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            for (int k = 0; k < 8 && in_ready !== 1'b1; k++) @(negedge clk);
            if (in_ready !== 1'b1) begin
                n_checks++;
                $display("FAIL feed_timeout: in_ready=%b want 1", in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (ones_count !== 6'd0) $display("FAIL reset_ones: got %0d want 0", ones_count); else n_pass++;
        n_checks++; if (transitions !== 6'd0) $display("FAIL reset_trans: got %0d want 0", transitions); else n_pass++;
        n_checks++; if (max_run !== 6'd0) $display("FAIL reset_maxrun: got %0d want 0", max_run); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL reset_pass: got %b want 0", pass); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else n_pass++;
    endtask

    task automatic test_all_ones();
        logic [7:0] w[4];
        w = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        pulse_start();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL ones_ready_after_start: got %b want 1", in_ready); else n_pass++;
        feed(w, 1'b0);
        n_checks++; if (done !== 1'b1) $display("FAIL ones_done: got %b want 1", done); else n_pass++;
        n_checks++; if (ones_count !== 6'd32) $display("FAIL ones_ones: got %0d want 32", ones_count); else n_pass++;
        n_checks++; if (transitions !== 6'd0) $display("FAIL ones_trans: got %0d want 0", transitions); else n_pass++;
        n_checks++; if (max_run !== 6'd32) $display("FAIL ones_maxrun: got %0d want 32", max_run); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL ones_pass: got %b want 0", pass); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL ones_ready_report: got %b want 0", in_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL ones_done_width: got %b want 0", done); else n_pass++;
        n_checks++; if (ones_count !== 6'd32) $display("FAIL ones_hold: got %0d want 32", ones_count); else n_pass++;
    endtask

    task automatic test_alternating();
        logic [7:0] w[4];
        w = '{8'h55, 8'h55, 8'h55, 8'h55};
        pulse_start();
        feed(w, 1'b0);
        n_checks++; if (done !== 1'b1) $display("FAIL alt_done: got %b want 1", done); else n_pass++;
        n_checks++; if (ones_count !== 6'd16) $display("FAIL alt_ones: got %0d want 16", ones_count); else n_pass++;
        n_checks++; if (transitions !== 6'd31) $display("FAIL alt_trans: got %0d want 31", transitions); else n_pass++;
        n_checks++; if (max_run !== 6'd1) $display("FAIL alt_maxrun: got %0d want 1", max_run); else n_pass++;
        n_checks++; if (pass !== 1'b1) $display("FAIL alt_pass: got %b want 1", pass); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_split_runs();
        logic [7:0] w[4];
        w = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
        pulse_start();
        feed(w, 1'b0);
        n_checks++; if (done !== 1'b1) $display("FAIL split_done: got %b want 1", done); else n_pass++;
        n_checks++; if (ones_count !== 6'd16) $display("FAIL split_ones: got %0d want 16", ones_count); else n_pass++;
        n_checks++; if (transitions !== 6'd4) $display("FAIL split_trans: got %0d want 4", transitions); else n_pass++;
        n_checks++; if (max_run !== 6'd8) $display("FAIL split_maxrun: got %0d want 8", max_run); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL split_pass: got %b want 0", pass); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_valid_gaps();
        logic [7:0] w[4];
        int d0;
        w = '{8'h55, 8'h55, 8'h55, 8'h55};
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL gaps_ready_idle: got %b want 0", in_ready); else n_pass++;
        in_valid = 1'b0;
        d0 = done_seen;
        pulse_start();
        feed(w, 1'b1);
        n_checks++; if (done !== 1'b1) $display("FAIL gaps_done: got %b want 1", done); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL gaps_ready_report: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (ones_count !== 6'd16) $display("FAIL gaps_ones: got %0d want 16", ones_count); else n_pass++;
        n_checks++; if (transitions !== 6'd31) $display("FAIL gaps_trans: got %0d want 31", transitions); else n_pass++;
        n_checks++; if (max_run !== 6'd1) $display("FAIL gaps_maxrun: got %0d want 1", max_run); else n_pass++;
        n_checks++; if (pass !== 1'b1) $display("FAIL gaps_pass: got %b want 1", pass); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (done_seen - d0 !== 1) $display("FAIL gaps_done_pulses: got %0d want 1", done_seen - d0); else n_pass++;
    endtask

    task automatic test_start_collision();
        logic [7:0] w[4];
        w = '{8'h55, 8'h55, 8'h55, 8'h55};
        pulse_start();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL coll_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (max_run !== 6'd1) $display("FAIL coll_outputs_kept: got %0d want 1", max_run); else n_pass++;
        feed(w, 1'b0);
        n_checks++; if (done !== 1'b1) $display("FAIL coll_done: got %b want 1", done); else n_pass++;
        n_checks++; if (ones_count !== 6'd16) $display("FAIL coll_ones: got %0d want 16", ones_count); else n_pass++;
        n_checks++; if (transitions !== 6'd31) $display("FAIL coll_trans: got %0d want 31", transitions); else n_pass++;
        n_checks++; if (max_run !== 6'd1) $display("FAIL coll_maxrun: got %0d want 1", max_run); else n_pass++;
        n_checks++; if (pass !== 1'b1) $display("FAIL coll_pass: got %b want 1", pass); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a[4];
        logic [7:0] b[4];
        a = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        b = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
        pulse_start();
        feed(a, 1'b0);
        n_checks++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else n_pass++;
        pulse_start();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL b2b_done_low: got %b want 0", done); else n_pass++;
        feed(b, 1'b0);
        n_checks++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else n_pass++;
        n_checks++; if (transitions !== 6'd4) $display("FAIL b2b_trans: got %0d want 4", transitions); else n_pass++;
        n_checks++; if (max_run !== 6'd8) $display("FAIL b2b_maxrun: got %0d want 8", max_run); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int d0;
        pulse_start();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        d0  = done_seen;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (ones_count !== 6'd0) $display("FAIL rst_ones: got %0d want 0", ones_count); else n_pass++;
        n_checks++; if (transitions !== 6'd0) $display("FAIL rst_trans: got %0d want 0", transitions); else n_pass++;
        n_checks++; if (max_run !== 6'd0) $display("FAIL rst_maxrun: got %0d want 0", max_run); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL rst_pass: got %b want 0", pass); else n_pass++;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (6) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_ready_stays_low: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (done_seen - d0 !== 0) $display("FAIL rst_no_done: got %0d want 0", done_seen - d0); else n_pass++;
        in_valid = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        done_seen = 0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_all_ones();
        test_alternating();
        test_split_runs();
        test_valid_gaps();
        test_start_collision();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
